// File: rtl/mod_arith_pkg.sv
// ============================================================================
//  Module      : mod_arith_pkg
//  Description : Shared constants and FSM state type for the GF(p) arithmetic
//                blocks (modular inverter, modular multiplier).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_arith_pkg;

    localparam int unsigned MOD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mod_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_mul_step.sv
// ============================================================================
//  Module      : mod_mul_step
//  Description : One interleaved shift-and-add iteration: (2*acc + bit*a) mod p.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             bit_in,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_red;
    logic [WIDTH:0] sum;

    // acc < p and a < p, so each stage stays below 2p and one subtract suffices
    always_comb begin
        p_ext   = {1'b0, p};
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
        sum     = bit_in ? (dbl_red + {1'b0, a}) : dbl_red;
        acc_next = (sum >= p_ext) ? WIDTH'(sum - p_ext) : WIDTH'(sum);
    end

endmodule

`default_nettype wire

// File: rtl/mod_mul.sv
// ============================================================================
//  Module      : mod_mul
//  Description : Sequential modular multiplier r = (a*b) mod p, MSB-first,
//                one multiplier bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mod_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] acc_step;
    logic             illegal;

    mod_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .p        (p_q),
        .bit_in   (b_q[cnt_q]),
        .acc_next (acc_step)
    );

    assign illegal = (p < WIDTH'(2)) || (a >= p) || (b >= p);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts like IDLE so a held start chains products back-to-back
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    p_d   = p;
                    acc_d = '0;
                    cnt_d = CNT_W'(WIDTH - 1);
                    if (illegal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        r_d     = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    r_d     = acc_step;
                    err_d   = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign r    = r_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_mul.sv
// ============================================================================
//  Module      : tb_mod_mul
//  Description : Scoreboard bench for mod_mul: stimulus pushes expected
//                results, a negedge monitor pops them on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_mul;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         err;

    mod_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int err;
        int cyc;
        int blen;
    } exp_t;

    exp_t q[$];

    int n_vec  = 0;
    int n_fail = 0;
    int run_len = 0;
    int idle_req = 0;
    int idle_ack = 0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    task automatic cmp(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every comparison happens here so the counters have one writer
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (busy) run_len++;
            if (done) begin
                if (q.size() == 0) begin
                    cmp("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    cmp("r", int'(r), e.r);
                    cmp("err", int'(err), e.err);
                    cmp("done_cycle", cyc, e.cyc);
                    cmp("busy_cycles", run_len, e.blen);
                    cmp("busy_at_done", int'(busy), 0);
                end
                run_len = 0;
            end
        end
        if (idle_req != idle_ack) begin
            idle_ack = idle_req;
            cmp("idle_r", int'(r), 0);
            cmp("idle_busy", int'(busy), 0);
            cmp("idle_done", int'(done), 0);
            cmp("idle_err", int'(err), 0);
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            cmp("queue_drained", q.size(), 0);
        end
    end

    task automatic issue(input int ai, input int bi, input int pi, input bit push);
        exp_t e;
        int   guard;
        bit   bad;
        guard = 0;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                $display("FAIL issue_wait: busy stuck high, got 1, expected 0");
                $fatal(1);
            end
        end
        a = W'(ai);
        b = W'(bi);
        p = W'(pi);
        start = 1'b1;
        if (push) begin
            bad    = (pi < 2) || (ai >= pi) || (bi >= pi);
            e.r    = bad ? 0 : (ai * bi) % pi;
            e.err  = bad ? 1 : 0;
            e.cyc  = cyc + 1 + (bad ? 0 : W);
            e.blen = bad ? 0 : W;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                $display("FAIL drain: %0d results outstanding, expected 0", q.size());
                $fatal(1);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    int inv13 [12] = '{1, 7, 9, 10, 8, 11, 2, 5, 3, 4, 6, 12};

    initial begin
        int c;
        int pr, ar, br;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        p = '0;
        repeat (3) @(posedge clk);
        #1 idle_req++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(5, 8, 13, 1);
        for (int i = 0; i < 12; i++) issue(i + 1, inv13[i], 13, 1);
        issue(0, 7, 13, 1);
        issue(12, 11, 13, 1);
        issue(13, 3, 13, 1);
        issue(0, 0, 1, 1);
        issue(3, 14, 13, 1);
        drain();

        // Start pulse during RUN with different operands must be ignored
        issue(9, 10, 13, 1);
        @(negedge clk);
        a = 4'd1; b = 4'd1; p = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Held start: second product accepted on the edge leaving DONE
        @(negedge clk);
        c = cyc;
        a = 4'd9; b = 4'd10; p = 4'd13; start = 1'b1;
        q.push_back('{12, 0, c + 1 + W, W});
        q.push_back('{1, 0, c + 2 + 2 * W, W});
        @(negedge clk);
        a = 4'd5; b = 4'd8;
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of a product: no done, outputs to reset values
        issue(9, 10, 13, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 idle_req++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            pr = $urandom_range(15, 2);
            ar = $urandom_range(pr - 1, 0);
            br = $urandom_range(pr - 1, 0);
            issue(ar, br, pr, 1);
        end
        drain();

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        if (!end_done) begin
            $display("FAIL end_handshake: got 0, expected 1");
            $fatal(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
